// File: rtl/dna_pkg.sv
// dna_pkg: shared symbol encoding (A/C/G/T), default symbol width and the count-width helper
package dna_pkg;
  localparam int SYM_W_DEF = 2;
  typedef enum logic [1:0] {SYM_A = 2'b00, SYM_C = 2'b01, SYM_G = 2'b10, SYM_T = 2'b11} sym_e;
  function automatic int cnt_w(input int syms);
    return $clog2(syms + 1);
  endfunction
endpackage

// File: rtl/dna_unpack_lane.sv
// dna_unpack_lane: one word register unpacked symbol by symbol; in: clk rst flush fire valid word cnt eos, out: ready avail sym last
module dna_unpack_lane import dna_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int SYM_W = SYM_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  localparam int SYMS = WORD_W / SYM_W,
  localparam int CNT_W = cnt_w(SYMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fire,
  input  logic              valid,
  output logic              ready,
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              eos,
  output logic              avail,
  output logic [SYM_W-1:0]  sym,
  output logic              last
);
  logic [WORD_W-1:0] word_q, shifted;
  logic [CNT_W-1:0] rem, cnt_ld, idx, cnt_eff;
  logic [31:0] shamt;
  logic eos_q;
  always_comb begin
    avail = rem != '0;
    ready = (!avail | (rem == CNT_W'(1) & fire)) & !flush;
    cnt_eff = cnt == '0 ? CNT_W'(SYMS) : cnt;
    idx = cnt_ld - rem;
    shamt = 32'(idx) * SYM_W;
    shifted = MSB_FIRST ? word_q << shamt : word_q >> shamt;
    sym = !avail ? '0 : MSB_FIRST ? shifted[WORD_W-1 -: SYM_W] : shifted[SYM_W-1:0];
    last = eos_q & rem == CNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_q <= '0;
      rem <= '0;
      cnt_ld <= '0;
      eos_q <= 1'b0;
    end else if (flush) begin
      rem <= '0;
      eos_q <= 1'b0;
    end else if (valid & ready) begin
      word_q <= word;
      rem <= cnt_eff;
      cnt_ld <= cnt_eff;
      eos_q <= eos;
    end else if (fire) begin
      rem <= rem - CNT_W'(1);
    end
endmodule

// File: rtl/dna_sym_streamer.sv
// dna_sym_streamer: pairs ref/read symbol lanes into one symbol-pair stream; in: clk rst flush_i, ref_*/read_* word lanes, sym_ready_i; out: lane ready_o, sym_valid_o, ref/read sym_o and last_o
module dna_sym_streamer import dna_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int SYM_W = SYM_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  localparam int SYMS = WORD_W / SYM_W,
  localparam int CNT_W = cnt_w(SYMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ref_valid_i,
  output logic              ref_ready_o,
  input  logic [WORD_W-1:0] ref_word_i,
  input  logic [CNT_W-1:0]  ref_cnt_i,
  input  logic              ref_eos_i,
  input  logic              read_valid_i,
  output logic              read_ready_o,
  input  logic [WORD_W-1:0] read_word_i,
  input  logic [CNT_W-1:0]  read_cnt_i,
  input  logic              read_eos_i,
  output logic              sym_valid_o,
  input  logic              sym_ready_i,
  output logic [SYM_W-1:0]  ref_sym_o,
  output logic [SYM_W-1:0]  read_sym_o,
  output logic              ref_last_o,
  output logic              read_last_o
);
  logic fire, ref_avail, read_avail;
  assign sym_valid_o = ref_avail & read_avail;
  assign fire = sym_valid_o & sym_ready_i;
  dna_unpack_lane #(.WORD_W(WORD_W), .SYM_W(SYM_W), .MSB_FIRST(MSB_FIRST)) u_ref (
    .clk(clk), .rst(rst), .flush(flush_i), .fire(fire),
    .valid(ref_valid_i), .ready(ref_ready_o), .word(ref_word_i), .cnt(ref_cnt_i), .eos(ref_eos_i),
    .avail(ref_avail), .sym(ref_sym_o), .last(ref_last_o)
  );
  dna_unpack_lane #(.WORD_W(WORD_W), .SYM_W(SYM_W), .MSB_FIRST(MSB_FIRST)) u_read (
    .clk(clk), .rst(rst), .flush(flush_i), .fire(fire),
    .valid(read_valid_i), .ready(read_ready_o), .word(read_word_i), .cnt(read_cnt_i), .eos(read_eos_i),
    .avail(read_avail), .sym(read_sym_o), .last(read_last_o)
  );
endmodule

// File: doc/dna_sym_streamer.md
DNA_SYM_STREAMER -- requirements
Module: dna_sym_streamer

Interface
REQ-001 Parameter WORD_W, default 32, packed input word width in bits.
REQ-002 Parameter SYM_W, default 2, symbol width; WORD_W SHALL be a multiple of SYM_W.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first symbol at bits [WORD_W-1 -: SYM_W], 0 = first symbol at [SYM_W-1:0].
REQ-004 Derived: SYMS = WORD_W/SYM_W; CNT_W = clog2(SYMS+1).
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush_i  in  1  synchronous clear of both lanes.
REQ-008 ref_valid_i  in  1  ref word offered.
REQ-009 ref_ready_o  out  1  ref lane accepts word.
REQ-010 ref_word_i  in  WORD_W  packed ref symbols.
REQ-011 ref_cnt_i  in  CNT_W  valid symbols in ref word, 1..SYMS.
REQ-012 ref_eos_i  in  1  ref word ends the ref sequence.
REQ-013 read_valid_i / read_ready_o / read_word_i / read_cnt_i / read_eos_i: same widths and meanings for the read lane.
REQ-014 sym_valid_o  out  1  symbol pair valid.
REQ-015 sym_ready_i  in  1  consumer accepts pair.
REQ-016 ref_sym_o, read_sym_o  out  SYM_W each  current symbols.
REQ-017 ref_last_o, read_last_o  out  1 each  current symbol is final symbol of an eos word.

Function
REQ-018 Input transfer on a lane occurs at a rising edge with valid_i & ready_o; output transfer ("fire") at a rising edge with sym_valid_o & sym_ready_i.
REQ-019 Each lane holds one word register, remaining-count rem (CNT_W) and eos flag; lane empty when rem == 0.
REQ-020 cnt_i == 0 SHALL be treated as SYMS.
REQ-021 lane ready_o = (rem == 0) | (rem == 1 & fire) & !flush_i, combinational.
REQ-022 sym_valid_o = (ref rem != 0) & (read rem != 0); both lanes advance together on fire, one symbol each.
REQ-023 Symbol select: index k = cnt_loaded - rem, symbol k taken MSB-first or LSB-first per MSB_FIRST; outputs combinational from registers.
REQ-024 Latency: word accepted at edge N -> its first symbol valid in cycle after edge N; no bubble between back-to-back words (reload on same edge as last-symbol fire).
REQ-025 Throughput: one pair per cycle while both lanes non-empty and sym_ready_i high.
REQ-026 last_o = eos flag & (rem == 1) for that lane.
REQ-027 Lanes with unequal counts: the lane with rem remaining waits for the other lane to reload; no symbol is dropped or duplicated.
REQ-028 sym_valid_o once asserted SHALL stay asserted with stable outputs until fire or flush.
REQ-029 flush_i: rem and eos of both lanes cleared next edge; flush wins over simultaneous load and fire; no input accepted in the flush cycle.
REQ-030 ref/read symbol outputs SHALL read 0 when their lane is empty.

Reset
REQ-031 On rst: word registers 0, rem 0, eos 0; hence sym_valid_o=0, sym outputs 0, last_o=0, ready_o=1 after rst deasserts.
REQ-032 rst asserted mid-word SHALL discard remaining symbols; no transfer completes on an edge during rst.

Structure
REQ-033 Package dna_pkg holds SYM_W default, symbol encoding constants (A=00, C=01, G=10, T=11) and the clog2-based CNT_W helper.
REQ-034 One sub-module dna_unpack_lane (word reg, rem counter, eos, symbol mux, ready logic), instantiated for ref and read; top holds pairing and fire logic.

Verification
REQ-035 Reset then ref=0x1B1B1B1B cnt 16, read=0xE4E4E4E4 cnt 16, sym_ready_i=1, MSB_FIRST=1 -> 16 consecutive pairs, ref 0,1,2,3,... read 3,2,1,0,...; valid deasserts after 16th.
REQ-036 Same words with MSB_FIRST=0 -> ref sequence 3,2,1,0 repeating; read 0,1,2,3 repeating.
REQ-037 ref cnt 3 eos=1, read cnt 5 -> 3 pairs, ref_last_o=1 on 3rd; 4th pair waits for next ref word, read symbol 4 then emitted unchanged.
REQ-038 sym_ready_i toggled 1,0,0,1 randomly over two back-to-back words -> outputs stable while stalled, 32 pairs, no gap when ready stays high across word boundary.
REQ-039 flush_i during symbol 7 with valid load offered -> next cycle sym_valid_o=0, both ready_o=1, offered word not captured.
REQ-040 rst pulse mid-word -> all outputs reset values within the reset cycle, stream restarts cleanly on next load.
